// File: rtl/mips_cpu_bus_mem_if.sv
// CPU load/store to Avalon-style bus bridge: lane steering, byteenables, load extension.
// Optional waitrequest watchdog enabled by defining MEM_IF_TIMEOUT_EN.
module mips_cpu_bus_mem_if #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] address,
   output logic              read,
   output logic              write,
   output logic [3:0]        byteenable,
   output logic [DATA_W-1:0] writedata,
   input  logic              waitrequest,
   input  logic [DATA_W-1:0] readdata
);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RDATA, S_RESP} state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic                r_write;
   logic [1:0]          r_size;
   logic                r_signed;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_err;

   logic                w_handshake;
   logic                w_bad_req;
   logic                w_tmo_hit;
   logic [3:0]          w_be;
   logic [DATA_W-1:0]   w_wd;
   logic [DATA_W-1:0]   w_shift;
   logic [DATA_W-1:0]   w_load_ext;

   assign w_handshake = (r_state == S_IDLE) && req_valid;

   assign w_bad_req = (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef MEM_IF_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] r_tmo_cnt;

   // Counter is held at zero outside BUS, so it is clear on every BUS entry.
   always_ff @(posedge clk) begin
      if (reset || (r_state != S_BUS)) begin
         r_tmo_cnt <= '0;
      end else if (waitrequest) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   assign w_tmo_hit = (r_state == S_BUS) && waitrequest
                   && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] w_unused_tmo;
   assign w_unused_tmo = TIMEOUT_CYCLES;
   assign w_tmo_hit    = 1'b0;
`endif

   always_comb begin
      w_be = 4'b1111;
      w_wd = r_wdata;
      case (r_size)
         2'b00: begin
            w_be = 4'b0001 << r_addr[1:0];
            w_wd = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wd = {2{r_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Accepted requests are naturally aligned, so one shift serves all sizes.
   assign w_shift = readdata >> {r_addr[1:0], 3'b000};

   always_comb begin
      case (r_size)
         2'b00:   w_load_ext = {{24{r_signed & w_shift[7]}},  w_shift[7:0]};
         2'b01:   w_load_ext = {{16{r_signed & w_shift[15]}}, w_shift[15:0]};
         default: w_load_ext = w_shift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      req_ready    = 1'b0;
      read         = 1'b0;
      write        = 1'b0;
      address      = '0;
      byteenable   = 4'b0000;
      writedata    = '0;
      resp_valid   = 1'b0;
      resp_rdata   = '0;
      resp_err     = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_next = w_bad_req ? S_RESP : S_BUS;
            end
         end
         S_BUS: begin
            read       = ~r_write;
            write      = r_write;
            address    = {r_addr[ADDR_W-1:2], 2'b00};
            byteenable = w_be;
            writedata  = w_wd;
            if (w_tmo_hit) begin
               w_state_next = S_RESP;
            end else if (!waitrequest) begin
               w_state_next = r_write ? S_RESP : S_RDATA;
            end
         end
         S_RDATA: begin
            w_state_next = S_RESP;
         end
         S_RESP: begin
            resp_valid   = 1'b1;
            resp_rdata   = r_rdata;
            resp_err     = r_err;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_write  <= 1'b0;
         r_size   <= 2'b00;
         r_signed <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_handshake) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
            r_err    <= w_bad_req;
         end
         if (r_state == S_RDATA) begin
            r_rdata <= w_load_ext;
         end
         if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mips_cpu_bus_mem_if.sv
// Directed bench for mips_cpu_bus_mem_if: expected responses queued at issue, checked on resp_valid.
module tb_mips_cpu_bus_mem_if;

`ifdef MEM_IF_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 256;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mips_cpu_bus_mem_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .address(address), .read(read), .write(write),
      .byteenable(byteenable), .writedata(writedata),
      .waitrequest(waitrequest), .readdata(readdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      check({tag, " idle req_ready"},  32'(req_ready),  32'd1);
      check({tag, " idle strobes"},    {30'd0, read, write}, 32'd0);
      check({tag, " idle resp"},       {30'd0, resp_valid, resp_err}, 32'd0);
      check({tag, " idle resp_rdata"}, resp_rdata, 32'd0);
      check({tag, " idle address"},    address,    32'd0);
      check({tag, " idle byteenable"}, 32'(byteenable), 32'd0);
      check({tag, " idle writedata"},  writedata,  32'd0);
      @(posedge clk); #1;
   endtask

   task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mem,
                      input int waits, input logic [31:0] e_addr, input logic [3:0] e_be,
                      input logic [31:0] e_wd, input logic [31:0] e_rdata, input logic e_err,
                      input int e_lat, input int e_nbus);
      exp_t e;
      exp_t got_e;
      int   c;
      int   nbus;
      bit   got;
      bit   rd_pending;
      check_idle(tag);
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = addr;
      req_wdata  = wd;
      e.rdata = e_rdata; e.err = e_err; e.lat = e_lat;
      exp_q.push_back(e);
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_write  = ~w;
      req_size   = 2'(~sz);
      req_signed = ~sg;
      req_addr   = $urandom;
      req_wdata  = $urandom;
      c = 1; nbus = 0; got = 0; rd_pending = 0;
      while (!got && c < 40) begin
         waitrequest = (nbus < waits);
         readdata    = rd_pending ? mem : 32'h5A5A_A5A5;
         rd_pending  = 0;
         @(negedge clk);
         if (read || write) begin
            check({tag, " strobe"},  {30'd0, read, write}, w ? 32'd1 : 32'd2);
            check({tag, " address"}, address, e_addr);
            check({tag, " byteenable"}, 32'(byteenable), 32'(e_be));
            if (w) check({tag, " writedata"}, writedata, e_wd);
            check({tag, " busy req_ready"}, 32'(req_ready), 32'd0);
            nbus++;
            if (read && !waitrequest) rd_pending = 1;
         end
         if (resp_valid) begin
            got   = 1;
            got_e = exp_q.pop_front();
            check({tag, " resp_rdata"}, resp_rdata, got_e.rdata);
            check({tag, " resp_err"},   32'(resp_err), 32'(got_e.err));
            check({tag, " latency"},    c, got_e.lat);
            check({tag, " resp req_ready"}, 32'(req_ready), 32'd0);
         end
         @(posedge clk); #1;
         c++;
      end
      waitrequest = 1'b0;
      check({tag, " response seen"}, 32'(got), 32'd1);
      check({tag, " bus cycles"}, nbus, e_nbus);
      $display("txn %s: w=%0b size=%0d addr=%h resp=%h err=%0b cycles=%0d",
               tag, w, sz, addr, resp_rdata, resp_err, c - 1);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0; waitrequest = 1'b0;
      readdata = '0;
      repeat (3) @(posedge clk);
      check_idle("reset");
      #1 reset = 1'b0;

      //   tag          w  sz    sg  addr   wdata         mem           waits e_addr e_be     e_wd          e_rdata       err lat nbus
      txn("sw",        1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0,        0,  2,  1);
      txn("lb",        0, 2'd0, 1, 32'h13, 32'h0,        32'h80FF7F01, 0, 32'h10, 4'b1000, 32'h0,        32'hFFFFFF80, 0,  3,  1);
      txn("lbu",       0, 2'd0, 0, 32'h13, 32'h0,        32'h80FF7F01, 0, 32'h10, 4'b1000, 32'h0,        32'h00000080, 0,  3,  1);
      txn("lb0",       0, 2'd0, 1, 32'h10, 32'h0,        32'h80FF7F01, 0, 32'h10, 4'b0001, 32'h0,        32'h00000001, 0,  3,  1);
      txn("lb1",       0, 2'd0, 1, 32'h11, 32'h0,        32'h80FF7F01, 0, 32'h10, 4'b0010, 32'h0,        32'h0000007F, 0,  3,  1);
      txn("lb2",       0, 2'd0, 1, 32'h12, 32'h0,        32'h80FF7F01, 0, 32'h10, 4'b0100, 32'h0,        32'hFFFFFFFF, 0,  3,  1);
      txn("sh",        1, 2'd1, 0, 32'h22, 32'h0000ABCD, 32'h0,        0, 32'h20, 4'b1100, 32'hABCDABCD, 32'h0,        0,  2,  1);
      txn("lh",        0, 2'd1, 1, 32'h22, 32'h0,        32'hABCDABCD, 0, 32'h20, 4'b1100, 32'h0,        32'hFFFFABCD, 0,  3,  1);
      txn("lhu",       0, 2'd1, 0, 32'h22, 32'h0,        32'hABCDABCD, 0, 32'h20, 4'b1100, 32'h0,        32'h0000ABCD, 0,  3,  1);
      txn("lhu_lo",    0, 2'd1, 0, 32'h20, 32'h0,        32'h1234F00D, 0, 32'h20, 4'b0011, 32'h0,        32'h0000F00D, 0,  3,  1);
      txn("sb",        1, 2'd0, 0, 32'h11, 32'h123456A5, 32'h0,        0, 32'h10, 4'b0010, 32'hA5A5A5A5, 32'h0,        0,  2,  1);
      txn("lw_mis",    0, 2'd2, 0, 32'h06, 32'h0,        32'h0,        0, 32'h0,  4'b0000, 32'h0,        32'h0,        1,  1,  0);
      txn("lh_mis",    0, 2'd1, 1, 32'h21, 32'h0,        32'h0,        0, 32'h0,  4'b0000, 32'h0,        32'h0,        1,  1,  0);
      txn("sz_ill",    1, 2'd3, 0, 32'h00, 32'h1111,     32'h0,        0, 32'h0,  4'b0000, 32'h0,        32'h0,        1,  1,  0);
      txn("lw_wait3",  0, 2'd2, 0, 32'h40, 32'h0,        32'h12345678, 3, 32'h40, 4'b1111, 32'h0,        32'h12345678, 0,  6,  4);
      txn("sw_wait2",  1, 2'd2, 0, 32'h44, 32'hCAFEF00D, 32'h0,        2, 32'h44, 4'b1111, 32'hCAFEF00D, 32'h0,        0,  4,  3);
      txn("lw_sgn",    0, 2'd2, 1, 32'h48, 32'h0,        32'h80000000, 0, 32'h48, 4'b1111, 32'h0,        32'h80000000, 0,  3,  1);
`ifdef MEM_IF_TIMEOUT_EN
      txn("lw_tmo",    0, 2'd2, 0, 32'h50, 32'h0,        32'hFFFFFFFF, 1000, 32'h50, 4'b1111, 32'h0,     32'h0,        1,  9,  8);
`endif

      // Reset during a stalled load aborts it silently.
      check_idle("rst_stall");
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
      req_addr = 32'h60; waitrequest = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("rst_stall read held", 32'(read), 32'd1);
         check("rst_stall address held", address, 32'h60);
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      waitrequest = 1'b0;
      @(negedge clk);
      check("rst_stall read dropped", 32'(read), 32'd0);
      check("rst_stall req_ready", 32'(req_ready), 32'd1);
      repeat (4) begin
         check("rst_stall no resp", 32'(resp_valid), 32'd0);
         @(negedge clk);
      end
      $display("txn rst_stall: load aborted by reset, read=%0b req_ready=%0b", read, req_ready);
      check("scoreboard drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
